// File: rtl/dptr_seq_pkg.sv
// dptr_seq_pkg: opcodes, NOP word and FSM state encodings shared by the instruction sequencer
package dptr_seq_pkg;
    localparam logic [5:0]  OP_BZ     = 6'h04;
    localparam logic [5:0]  OP_HALT   = 6'h3F;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/instr_buf.sv
// instr_buf: DEPTH x 32 program RAM, synchronous write, asynchronous read
module instr_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a program, issues one word per cycle to the datapath, resolves BZ/HALT locally
module instr_sequencer
    import dptr_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [31:0]   load_data,
    input  logic          clr_prog,
    input  logic          start,
    input  logic          ZF,
    output logic [31:0]   Instr,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   cycles
);
    state_t        state;
    logic [AW:0]   prog_len;
    logic          issue_q, zf_q;
    logic [31:0]   w;
    logic          hs, halt, is_bz, zf_eff;
    logic [AW-1:0] waddr, pc_inc, bz_target;

    assign load_ready = !rst && state == S_IDLE && prog_len != (AW+1)'(DEPTH);
    assign hs         = load_valid && load_ready;
    assign waddr      = clr_prog ? '0 : prog_len[AW-1:0];
    assign halt       = {1'b0, pc} >= prog_len || w[31:26] == OP_HALT;
    assign is_bz      = w[31:26] == OP_BZ;
    // ZF is only meaningful while a real instruction sits on Instr; otherwise use the held copy
    assign zf_eff     = issue_q ? ZF : zf_q;
    assign pc_inc     = pc + AW'(1);
    assign bz_target  = pc_inc + w[AW-1:0];
    assign busy       = state != S_IDLE;

    instr_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (hs),
        .waddr (waddr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            Instr    <= NOP_INSTR;
            pc       <= '0;
            done     <= 1'b0;
            cycles   <= '0;
            prog_len <= '0;
            issue_q  <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            issue_q <= 1'b0;
            done    <= 1'b0;
            if (issue_q) zf_q <= ZF;
            case (state)
                S_IDLE: begin
                    if (hs) prog_len <= (clr_prog ? '0 : prog_len) + (AW+1)'(1);
                    else if (clr_prog) prog_len <= '0;
                    if (start) begin
                        state  <= S_RUN;
                        pc     <= '0;
                        cycles <= '0;
                    end
                end
                S_RUN: begin
                    if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
                    if (halt) begin
                        Instr <= NOP_INSTR;
                        state <= S_DRAIN;
                    end else if (is_bz) begin
                        Instr <= NOP_INSTR;
                        pc    <= zf_eff ? bz_target : pc_inc;
                    end else begin
                        Instr   <= w;
                        pc      <= pc_inc;
                        issue_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    Instr <= NOP_INSTR;
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: random and directed programs checked cycle by cycle against a program-level model
module tb_instr_sequencer;
    import dptr_seq_pkg::*;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst, load_valid, clr_prog, start, ZF, zf_noise;
    logic [31:0]   load_data, Instr;
    logic          load_ready, busy, done;
    logic [AW-1:0] pc;
    logic [15:0]   cycles;
    int            n_cmp = 0, n_bad = 0;
    logic [31:0]   mbuf [DEPTH];
    int            mlen;
    logic          mflag;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .clr_prog(clr_prog), .start(start), .ZF(ZF),
        .Instr(Instr), .pc(pc), .busy(busy), .done(done), .cycles(cycles)
    );

    // toy datapath: SUB of a register with itself yields zero; ZF is garbage on a NOP
    function automatic logic zf_of(input logic [31:0] i);
        return i[5:0] == 6'h22 && i[25:21] == i[20:16];
    endfunction
    assign ZF = (Instr != 32'd0) ? zf_of(Instr) : zf_noise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        zf_noise = 1'($urandom_range(0, 1));
    endtask

    task automatic load_word(input logic [31:0] w, input bit clr);
        bit rdy;
        rdy = mlen != DEPTH;
        load_valid = 1'b1; load_data = w; clr_prog = clr;
        #1 check("load_ready", load_ready, rdy);
        if (clr) mlen = 0;
        if (rdy) begin mbuf[mlen] = w; mlen++; end
        cyc();
        load_valid = 1'b0; clr_prog = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return {OP_BZ, 10'd0, 16'($urandom_range(0, 3) + 64 * $urandom_range(0, 1000))};
        if (r == 2) return {OP_HALT, 26'($urandom)};
        w = $urandom;
        w[31:26] = 6'($urandom_range(0, 62));
        if (w[31:26] == OP_BZ) w[31:26] = 6'h00;
        if ($urandom_range(0, 1) == 1) begin w[5:0] = 6'h22; w[20:16] = w[25:21]; end
        return w | 32'h800;
    endfunction

    // program-level model: walk the buffer, producing Instr/pc after each RUN edge
    task automatic run_prog(input bit poke_start);
        logic [31:0]   ei [$];
        logic [AW-1:0] ep [$];
        int            p;
        logic          f;
        logic [31:0]   w;
        p = 0; f = mflag;
        for (int s = 0; s < 500; s++) begin
            w = (p < mlen) ? mbuf[p] : {OP_HALT, 26'd0};
            if (w[31:26] == OP_HALT) begin
                ei.push_back(32'd0); ep.push_back(p[AW-1:0]);
                break;
            end
            if (w[31:26] == OP_BZ) begin
                ei.push_back(32'd0);
                p = f ? (p + 1 + int'(w[15:0])) % DEPTH : (p + 1) % DEPTH;
            end else begin
                ei.push_back(w);
                f = zf_of(w);
                p = (p + 1) % DEPTH;
            end
            ep.push_back(p[AW-1:0]);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("run_busy", busy, 1); check("run_pc0", pc, 0); check("run_cyc0", cycles, 0);
        foreach (ei[i]) begin
            if (poke_start && i == 1) start = 1'b1;
            cyc();
            start = 1'b0;
            check("instr", Instr, ei[i]);
            check("pc", pc, ep[i]);
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("ready_run", load_ready, 0);
            check("cycles", cycles, 32'(i + 1));
        end
        cyc();
        check("done", done, 1); check("busy_off", busy, 0); check("instr_drain", Instr, 0);
        check("cycles_hold", cycles, 32'(ei.size()));
        cyc();
        check("done_pulse", done, 0);
        mflag = f;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; clr_prog = 1'b0; start = 1'b0; load_data = '0; zf_noise = 1'b0;
        mlen = 0; mflag = 1'b0;
        cyc(); cyc();
        check("rst_instr", Instr, 0); check("rst_pc", pc, 0); check("rst_busy", busy, 0);
        check("rst_done", done, 0); check("rst_cycles", cycles, 0); check("rst_ready", load_ready, 0);
        rst = 1'b0;
        // ADD then HALT
        load_word({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0);
        load_word({OP_HALT, 26'd0}, 1'b0);
        run_prog(1'b0);
        // BZ taken (SUB r3,r1,r1 gives zero) and not taken (SUB r3,r1,r2)
        for (int t = 0; t < 2; t++) begin
            load_word({6'h00, 5'd1, t ? 5'd2 : 5'd1, 5'd3, 5'd0, 6'h22}, 1'b1);
            load_word({OP_BZ, 10'd0, 16'd1}, 1'b0);
            load_word({6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20}, 1'b0);
            load_word({6'h00, 5'd7, 5'd8, 5'd9, 5'd0, 6'h25}, 1'b0);
            run_prog(1'b0);
        end
        // branch offset wraps modulo DEPTH: from pc 1, +66 lands on 4
        load_word({6'h00, 5'd2, 5'd2, 5'd1, 5'd0, 6'h22}, 1'b1);
        load_word({OP_BZ, 10'd0, 16'd66}, 1'b0);
        for (int i = 0; i < 4; i++) load_word(32'h0000_0800 | 32'(i << 16), 1'b0);
        run_prog(1'b1);
        // clr_prog with a handshake in the same cycle keeps just that word
        load_word(32'h0042_1820, 1'b1);
        run_prog(1'b0);
        // fill the buffer; the extra offer must be refused
        for (int i = 0; i < DEPTH; i++) load_word(i == DEPTH - 1 ? {OP_HALT, 26'd0} : rand_word(), i == 0);
        load_word(32'h0000_0820, 1'b0);
        check("full_ready", load_ready, 0);
        run_prog(1'b0);
        // random programs
        for (int n = 0; n < 25; n++) begin
            int len;
            len = $urandom_range(0, 20);
            if (len == 0) begin
                clr_prog = 1'b1; cyc(); clr_prog = 1'b0; mlen = 0;
            end
            for (int i = 0; i < len; i++) load_word(rand_word(), i == 0);
            run_prog(n % 5 == 0);
        end
        // tight BZ loop: cycles saturates, then reset mid-RUN
        load_word({6'h00, 5'd3, 5'd3, 5'd3, 5'd0, 6'h22}, 1'b1);
        load_word({OP_BZ, 10'd0, 16'hFFFF}, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (65600) cyc();
        check("sat_cycles", cycles, 16'hFFFF); check("sat_busy", busy, 1); check("sat_pc", pc, 1);
        rst = 1'b1;
        cyc();
        check("mid_rst_instr", Instr, 0); check("mid_rst_busy", busy, 0); check("mid_rst_pc", pc, 0);
        check("mid_rst_cycles", cycles, 0); check("mid_rst_ready", load_ready, 0);
        rst = 1'b0;
        #1 check("post_rst_ready", load_ready, 1);
        cyc();
        check("post_rst_done", done, 0);
        mlen = 0; mflag = 1'b0;
        run_prog(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
